// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter for the shared main-memory data port.
// One transaction in flight; a stalled memory is cut off by a watchdog.

module dmem_arbiter_resp #(
    parameter int W = 32
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_rdata,
    input  logic         i_err,
    output logic         o_valid,
    output logic [W-1:0] o_rdata,
    output logic         o_err
);
    // Loaded on the completing BUSY edge, so the pulse lines up with RESP
    // and self-clears one cycle later.
    always_ff @(posedge i_clk) begin
        if (i_rst || !i_load) begin
            o_valid <= 1'b0;
            o_rdata <= '0;
            o_err   <= 1'b0;
        end else begin
            o_valid <= 1'b1;
            o_rdata <= i_rdata;
            o_err   <= i_err;
        end
    end
endmodule

module dmem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req0_valid_i,
    input  logic                  req0_we_i,
    input  logic [ADDR_WIDTH-1:0] req0_addr_i,
    input  logic [ADDR_WIDTH-1:0] req0_wdata_i,
    output logic                  req0_ready_o,
    output logic                  resp0_valid_o,
    output logic [ADDR_WIDTH-1:0] resp0_rdata_o,
    output logic                  resp0_err_o,
    input  logic                  req1_valid_i,
    input  logic                  req1_we_i,
    input  logic [ADDR_WIDTH-1:0] req1_addr_i,
    input  logic [ADDR_WIDTH-1:0] req1_wdata_i,
    output logic                  req1_ready_o,
    output logic                  resp1_valid_o,
    output logic [ADDR_WIDTH-1:0] resp1_rdata_o,
    output logic                  resp1_err_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [ADDR_WIDTH-1:0] mem_wdata_o,
    input  logic [ADDR_WIDTH-1:0] mem_rdata_i,
    input  logic                  mem_ack_i
);
    localparam int NUM_PORTS = 2;
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT - 1);
    localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(3);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

    state_t                  r_state;
    logic                    r_last;
    logic                    r_owner;
    logic                    r_mem_req;
    logic                    r_we;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [ADDR_WIDTH-1:0]   r_wdata;
    logic [CW-1:0]           r_cnt;

    logic [NUM_PORTS-1:0]                 w_req_v;
    logic [NUM_PORTS-1:0]                 w_req_we;
    logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] w_req_addr;
    logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] w_req_wdata;
    logic [NUM_PORTS-1:0]                 w_gnt;
    logic                                 w_idle;
    logic                                 w_accept;
    logic                                 w_sel;
    logic                                 w_done;
    logic                                 w_done_err;
    logic [ADDR_WIDTH-1:0]                w_done_rdata;
    logic [NUM_PORTS-1:0]                 w_load;
    logic [NUM_PORTS-1:0]                 w_resp_valid;
    logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] w_resp_rdata;
    logic [NUM_PORTS-1:0]                 w_resp_err;

    assign w_req_v     = {req1_valid_i, req0_valid_i};
    assign w_req_we    = {req1_we_i, req0_we_i};
    assign w_req_addr  = {req1_addr_i, req0_addr_i};
    assign w_req_wdata = {req1_wdata_i, req0_wdata_i};

    // On a tie the port that did not win last time gets the grant.
    assign w_gnt[0] = w_req_v[0] & (~w_req_v[1] | r_last);
    assign w_gnt[1] = w_req_v[1] & (~w_req_v[0] | ~r_last);

    assign w_idle       = (r_state == S_IDLE) & ~rst_i;
    assign w_accept     = w_idle & (|w_gnt);
    assign w_sel        = w_gnt[1];
    assign req0_ready_o = w_idle & w_gnt[0];
    assign req1_ready_o = w_idle & w_gnt[1];

    // Ack beats the watchdog when both land on the same cycle.
    assign w_done       = (r_state == S_BUSY) & (mem_ack_i | (r_cnt == TMAX));
    assign w_done_err   = ~mem_ack_i;
    assign w_done_rdata = (mem_ack_i & ~r_we) ? mem_rdata_i : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_last    <= 1'b1;
            r_owner   <= 1'b0;
            r_mem_req <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_cnt     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_owner   <= w_sel;
                        r_last    <= w_sel;
                        r_we      <= w_req_we[w_sel];
                        r_addr    <= w_req_addr[w_sel] & WORD_MASK;
                        r_wdata   <= w_req_wdata[w_sel];
                        r_mem_req <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (w_done) begin
                        r_mem_req <= 1'b0;
                        r_state   <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    r_cnt   <= '0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_mem_req <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_req_o   = r_mem_req;
    assign mem_we_o    = r_we;
    assign mem_addr_o  = r_addr;
    assign mem_wdata_o = r_wdata;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_resp
        assign w_load[p] = w_done & (r_owner == 1'(p));

        dmem_arbiter_resp #(.W(ADDR_WIDTH)) u_resp (
            .i_clk   (clk_i),
            .i_rst   (rst_i),
            .i_load  (w_load[p]),
            .i_rdata (w_done_rdata),
            .i_err   (w_done_err),
            .o_valid (w_resp_valid[p]),
            .o_rdata (w_resp_rdata[p]),
            .o_err   (w_resp_err[p])
        );
    end

    assign resp0_valid_o = w_resp_valid[0];
    assign resp0_rdata_o = w_resp_rdata[0];
    assign resp0_err_o   = w_resp_err[0];
    assign resp1_valid_o = w_resp_valid[1];
    assign resp1_rdata_o = w_resp_rdata[1];
    assign resp1_err_o   = w_resp_err[1];
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter sharing the single main data memory port between the data-cache refill/write-back path (port 0) and the instruction-fetch refill path (port 1).
- Sits between the cache controllers and the word-aligned main memory.
- Accepts one transaction at a time, drives the memory request until the memory acknowledges, and returns the read data or completion to the owning requester.
- Uses round-robin fairness and a watchdog timeout on a stalled memory.

Parameters:
- ADDR_WIDTH, 32, address and data width in bits.
- TIMEOUT, 64, maximum cycles to wait for mem_ack_i before aborting with an error. Must be 2 or greater.

Ports:
- clk_i  input  1  clock; all state changes on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- req0_valid_i  input  1  port 0 request valid.
- req0_we_i  input  1  port 0 write enable (1 = store).
- req0_addr_i  input  ADDR_WIDTH  port 0 byte address.
- req0_wdata_i  input  ADDR_WIDTH  port 0 write data.
- req0_ready_o  output  1  port 0 request accepted this cycle.
- resp0_valid_o  output  1  port 0 response pulse.
- resp0_rdata_o  output  ADDR_WIDTH  port 0 read data.
- resp0_err_o  output  1  port 0 timeout error, qualified by resp0_valid_o.
- req1_valid_i, req1_we_i, req1_addr_i, req1_wdata_i, req1_ready_o, resp1_valid_o, resp1_rdata_o, resp1_err_o: identical set for port 1.
- mem_req_o  output  1  memory access strobe.
- mem_we_o  output  1  memory write enable.
- mem_addr_o  output  ADDR_WIDTH  word-aligned address; bits [1:0] forced to 0.
- mem_wdata_o  output  ADDR_WIDTH  memory write data.
- mem_rdata_i  input  ADDR_WIDTH  memory read data, valid when mem_ack_i = 1.
- mem_ack_i  input  1  memory completion, one-cycle pulse.

Behaviour:
- States: IDLE, BUSY, RESP. Reset enters IDLE.
- Reset values: all outputs 0; last_grant = 1, so port 0 wins the first tie; timeout counter 0.
- IDLE:
  - req*_ready_o is combinational: asserted for at most one port, only in IDLE.
  - Single request: that port wins.
  - Both requesting: the port not equal to last_grant wins.
  - On acceptance, register owner, we, aligned address and wdata; set last_grant = owner; go to BUSY.
- BUSY:
  - mem_req_o = 1, with mem_we_o/mem_addr_o/mem_wdata_o held from the registered values.
  - Counter increments each cycle.
  - mem_ack_i = 1: capture mem_rdata_i (writes capture 0), clear err, go to RESP.
  - Counter reaches TIMEOUT-1 without ack: set err, rdata = 0, drop mem_req_o, go to RESP.
  - Ack in the same cycle as the timeout: ack wins, err = 0.
- RESP:
  - The owner's resp_valid_o = 1 for exactly one cycle, with rdata and err.
  - The other port's resp outputs stay 0.
  - Next state is IDLE; counter clears.
- Requester obligations: requests must be held stable until ready. A request dropped before acceptance is simply not served.
- Latency with immediate ack:
  - accept at cycle T;
  - mem_req_o high at T+1;
  - ack at T+1;
  - resp_valid_o at T+2;
  - next accept possible at T+3.
- Stray mem_ack_i in IDLE or RESP: ignored.
- Reset mid-transaction: immediately returns to IDLE with all outputs 0. The in-flight transaction is dropped, no response is issued, and last_grant returns to 1.

Test Plan:
- Port 0 read only, addr 0x0000_1006, memory returns 0xDEAD_BEEF with ack 2 cycles after mem_req_o rises -> mem_addr_o = 0x0000_1004, mem_we_o = 0; resp0_valid_o one cycle after ack with rdata 0xDEAD_BEEF and err 0; resp1_valid_o never asserts.
- Both ports request continuously from reset, port 0 read and port 1 write of 0x1234_5678 to 0x20 -> grant order 0, 1, 0, 1. On port 1 grants, mem_we_o = 1 and mem_wdata_o = 0x1234_5678. Each port gets exactly one resp pulse per grant.
- Port 1 read, mem_ack_i held low, TIMEOUT = 64 -> mem_req_o high for exactly 64 cycles, then resp1_valid_o = 1 with err 1 and rdata 0. The arbiter returns to IDLE and the next port 0 request is accepted.
- mem_ack_i arriving on exactly cycle 64 of BUSY -> resp err = 0 and rdata equal to the memory data.
- Assert rst_i for one cycle while BUSY -> next cycle mem_req_o = 0 and no resp pulse. A subsequent simultaneous request from both ports grants port 0 first.
- Pulse mem_ack_i while IDLE with no requests -> no resp_valid on either port and state unchanged. A following request completes with normal latency.
